// File: rtl/ising_weight_loader.sv
// ising_weight_loader: streams pair weights into the packed matrix weight bus
// and sequences the matrix's active-low oscillator reset (load, settle, run).
module ising_weight_loader #(
  parameter  int N             = 3,
  parameter  int NUM_WEIGHTS   = 5,
  parameter  int SETTLE_CYCLES = 16,
  parameter  int RUN_W         = 16,
  localparam int W             = $clog2(NUM_WEIGHTS),
  localparam int IW            = (N > 2) ? $clog2(N) : 1,
  localparam int P             = N * (N - 1) / 2,
  localparam int WB            = W * P
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              wr_valid,
  input  logic [W-1:0]      wr_data,
  output logic              wr_ready,
  output logic [IW-1:0]     cur_i,
  output logic [IW-1:0]     cur_j,
  output logic [WB-1:0]     weights,
  output logic              core_rstn,
  output logic              busy,
  output logic              run_done,
  output logic              err
);

  localparam int KW = (P > 1) ? $clog2(P) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

  state_t            state_q;
  logic [IW-1:0]     i_q, j_q;
  logic [KW-1:0]     k_q;
  logic [WB-1:0]     weights_q;
  logic [SW-1:0]     settle_cnt_q;
  logic [RUN_W-1:0]  run_len_q, run_cnt_q;
  logic              wr_ready_q, core_rstn_q, busy_q, run_done_q, err_q;

  logic              oor_d;
  logic [W-1:0]      field_d;
  logic              beat_d;

  // Clamp out-of-range weight codes to the largest legal code.
  always_comb begin
    oor_d   = (int'(wr_data) >= NUM_WEIGHTS);
    field_d = oor_d ? W'(NUM_WEIGHTS - 1) : wr_data;
    beat_d  = wr_valid && wr_ready_q;
  end

  // Load/settle/run sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= IW'(1);
      k_q          <= '0;
      weights_q    <= '0;
      settle_cnt_q <= '0;
      run_len_q    <= '0;
      run_cnt_q    <= '0;
      wr_ready_q   <= 1'b0;
      core_rstn_q  <= 1'b0;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      run_done_q <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        wr_ready_q  <= 1'b0;
        core_rstn_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= LOAD;
              run_len_q  <= run_cycles;
              i_q        <= '0;
              j_q        <= IW'(1);
              k_q        <= '0;
              err_q      <= 1'b0;
              wr_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
          LOAD: begin
            if (beat_d) begin
              for (int unsigned f = 0; f < P; f++) begin
                if (KW'(f) == k_q) weights_q[f*W +: W] <= field_d;
              end
              if (oor_d) err_q <= 1'b1;
              if (k_q == KW'(P - 1)) begin
                // Pair counter parks at (0,1) once the matrix is fully loaded.
                state_q      <= SETTLE;
                wr_ready_q   <= 1'b0;
                settle_cnt_q <= SW'(SETTLE_CYCLES - 1);
                i_q          <= '0;
                j_q          <= IW'(1);
                k_q          <= '0;
              end else begin
                k_q <= k_q + KW'(1);
                if (j_q == IW'(N - 1)) begin
                  i_q <= i_q + IW'(1);
                  j_q <= i_q + IW'(2);
                end else begin
                  j_q <= j_q + IW'(1);
                end
              end
            end
          end
          SETTLE: begin
            if (settle_cnt_q == '0) begin
              state_q     <= RUN;
              core_rstn_q <= 1'b1;
              run_cnt_q   <= run_len_q - RUN_W'(1);
            end else begin
              settle_cnt_q <= settle_cnt_q - SW'(1);
            end
          end
          RUN: begin
            // A zero run length means free-running until abort.
            if (run_len_q != '0) begin
              if (run_cnt_q == '0) begin
                state_q     <= IDLE;
                core_rstn_q <= 1'b0;
                busy_q      <= 1'b0;
                run_done_q  <= 1'b1;
              end else begin
                run_cnt_q <= run_cnt_q - RUN_W'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wr_ready  = wr_ready_q;
  assign cur_i     = i_q;
  assign cur_j     = j_q;
  assign weights   = weights_q;
  assign core_rstn = core_rstn_q;
  assign busy      = busy_q;
  assign run_done  = run_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ising_weight_loader.sv
// tb_ising_weight_loader: directed sequence with randomized weight codes,
// beat gaps and run lengths, checked against a pair-indexed reference model.
module tb_ising_weight_loader;

  localparam int N             = 3;
  localparam int NUM_WEIGHTS   = 5;
  localparam int SETTLE_CYCLES = 16;
  localparam int RUN_W         = 16;
  localparam int W             = 3;
  localparam int IW            = 2;
  localparam int P             = 3;
  localparam int WB            = 9;

  logic             clk = 1'b0;
  logic             rst, start, abort, wr_valid;
  logic [RUN_W-1:0] run_cycles;
  logic [W-1:0]     wr_data;
  logic             wr_ready, core_rstn, busy, run_done, err;
  logic [IW-1:0]    cur_i, cur_j;
  logic [WB-1:0]    weights;

  int checks   = 0;
  int failures = 0;

  int codes [P];
  int ref_w [P];
  bit ref_err;

  ising_weight_loader #(
    .N(N), .NUM_WEIGHTS(NUM_WEIGHTS), .SETTLE_CYCLES(SETTLE_CYCLES), .RUN_W(RUN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .run_cycles(run_cycles),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .cur_i(cur_i), .cur_j(cur_j), .weights(weights), .core_rstn(core_rstn),
    .busy(busy), .run_done(run_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bus built from pair coordinates with the closed-form index.
  function automatic logic [WB-1:0] ref_bus();
    logic [WB-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        int k;
        k = N*i - i*(i+1)/2 + j - i - 1;
        b = b | (WB'(ref_w[k]) << (k*W));
      end
    end
    return b;
  endfunction

  task automatic start_seq(input int rc);
    chk("idle_ready", wr_ready, 0);
    start = 1'b1;
    run_cycles = RUN_W'(rc);
    tick();
    start = 1'b0;
    run_cycles = RUN_W'($urandom);
    ref_err = 1'b0;
    chk("start_ready", wr_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_err_clr", err, 0);
  endtask

  task automatic send_beats(input bit gaps);
    int b;
    b = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        chk("cur_i", cur_i, i);
        chk("cur_j", cur_j, j);
        if (gaps) begin
          int g;
          g = $urandom_range(0, 3);
          for (int t = 0; t < g; t++) begin
            wr_valid = 1'b0;
            wr_data  = W'($urandom);
            tick();
          end
          chk("gap_hold", weights, ref_bus());
        end
        wr_valid = 1'b1;
        wr_data  = W'(codes[b]);
        tick();
        ref_w[b] = (codes[b] >= NUM_WEIGHTS) ? NUM_WEIGHTS - 1 : codes[b];
        if (codes[b] >= NUM_WEIGHTS) ref_err = 1'b1;
        b++;
      end
    end
    // Keep offering beats after LOAD; none may be taken.
    wr_valid = 1'b1;
    wr_data  = W'($urandom);
    chk("load_weights", weights, ref_bus());
    chk("load_err", err, ref_err);
    chk("load_done_ready", wr_ready, 0);
  endtask

  task automatic wait_rstn(output int lat);
    lat = 1;
    while (core_rstn !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic measure_run(output int hi);
    hi = 0;
    while (core_rstn === 1'b1 && hi < 2000) begin
      tick();
      hi++;
    end
  endtask

  task automatic full_run(input int rc, input bit gaps);
    int lat, hi;
    start_seq(rc);
    send_beats(gaps);
    wait_rstn(lat);
    chk("settle_latency", lat, SETTLE_CYCLES + 1);
    measure_run(hi);
    chk("run_len", hi, rc);
    chk("run_done_pulse", run_done, 1);
    chk("end_busy", busy, 0);
    chk("end_rstn", core_rstn, 0);
    wr_valid = 1'b0;
    tick();
    chk("run_done_clear", run_done, 0);
    chk("end_weights_hold", weights, ref_bus());
  endtask

  initial begin
    int lat, rc;
    bit seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_valid = 1'b0;
    wr_data = '0; run_cycles = '0;
    foreach (ref_w[k]) ref_w[k] = 0;
    ref_err = 1'b0;
    tick(); tick();
    chk("rst_weights", weights, 0);
    chk("rst_rstn", core_rstn, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", run_done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur_i", cur_i, 0);
    chk("rst_cur_j", cur_j, 1);
    rst = 1'b0;
    tick();

    // Beats 1,2,3 back to back, run window of 5.
    codes = '{1, 2, 3};
    full_run(5, 1'b0);
    chk("s1_literal", weights, 9'h0D1);

    // Out-of-range code on the second beat.
    codes = '{$urandom_range(0, 4), 7, $urandom_range(0, 4)};
    full_run($urandom_range(1, 8), 1'b0);
    chk("s3_field_clamped", weights[5:3], 4);
    chk("s3_err_sticky", err, 1);

    // Same codes as the first sequence, with random gaps.
    codes = '{1, 2, 3};
    full_run($urandom_range(1, 8), 1'b1);
    chk("s4_literal", weights, 9'h0D1);

    // Random sequences overwrite every field.
    for (int r = 0; r < 4; r++) begin
      foreach (codes[k]) codes[k] = $urandom_range(0, 7);
      full_run($urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end

    // Abort while settling.
    foreach (codes[k]) codes[k] = $urandom_range(0, 4);
    start_seq(4);
    send_beats(1'b0);
    repeat ($urandom_range(1, 10)) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wr_valid = 1'b0;
    chk("ab_s_busy", busy, 0);
    chk("ab_s_rstn", core_rstn, 0);
    chk("ab_s_done", run_done, 0);
    chk("ab_s_weights", weights, ref_bus());
    seen = 1'b0;
    for (int t = 0; t < 25; t++) begin
      tick();
      if (core_rstn !== 1'b0 || run_done !== 1'b0) seen = 1'b1;
    end
    chk("ab_s_quiet", seen, 0);

    // Free-running window ended by abort; start during RUN is ignored.
    foreach (codes[k]) codes[k] = $urandom_range(0, 4);
    start_seq(0);
    send_beats(1'b0);
    wait_rstn(lat);
    chk("free_latency", lat, SETTLE_CYCLES + 1);
    repeat (30) tick();
    chk("free_rstn_high", core_rstn, 1);
    start = 1'b1;
    run_cycles = RUN_W'(2);
    tick();
    start = 1'b0;
    chk("run_start_ready", wr_ready, 0);
    chk("run_start_rstn", core_rstn, 1);
    chk("run_start_busy", busy, 1);
    repeat (5) tick();
    chk("run_start_still", core_rstn, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wr_valid = 1'b0;
    chk("ab_r_rstn", core_rstn, 0);
    chk("ab_r_done", run_done, 0);
    chk("ab_r_busy", busy, 0);
    tick();
    chk("ab_r_done2", run_done, 0);
    chk("ab_r_weights", weights, ref_bus());

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_ready", wr_ready, 0);

    // Reset in the middle of LOAD after one beat.
    rc = $urandom_range(1, 8);
    start_seq(rc);
    wr_valid = 1'b1;
    wr_data  = W'(7);
    tick();
    chk("mid_err", err, 1);
    chk("mid_cur_j", cur_j, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_valid = 1'b0;
    chk("mrst_weights", weights, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", wr_ready, 0);
    chk("mrst_cur_i", cur_i, 0);
    chk("mrst_cur_j", cur_j, 1);
    chk("mrst_err", err, 0);
    chk("mrst_rstn", core_rstn, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
